// File: rtl/mine_placer.sv
// Mine placer: seeds an 8x8 board with NUM_MINES mines from a free-running
// LFSR, keeping the 3x3 zone around the player's first cell clear.
module mine_placer #(
  parameter int          NUM_MINES = 10,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mine_start,
  input  logic [2:0]  safe_row,
  input  logic [2:0]  safe_col,
  output logic        mine_done,
  output logic        busy,
  output logic [63:0] mine_map,
  output logic [5:0]  mine_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_GEN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [5:0] TARGET = 6'(NUM_MINES);

  logic [1:0]  state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [63:0] map_q, map_d;
  logic [5:0]  count_q, count_d;
  logic        done_q, done_d;
  logic [2:0]  srow_q, srow_d;
  logic [2:0]  scol_q, scol_d;

  logic [5:0]  idx;
  logic [3:0]  dr, dc;
  logic        near_r, near_c;
  logic        accept;

  // Candidate cell and its rejection test
  always_comb begin
    idx    = lfsr_q[5:0];
    dr     = {1'b0, idx[5:3]} - {1'b0, srow_q};
    dc     = {1'b0, idx[2:0]} - {1'b0, scol_q};
    near_r = (dr == 4'd0) || (dr == 4'd1) || (dr == 4'hF);
    near_c = (dc == 4'd0) || (dc == 4'd1) || (dc == 4'hF);
    accept = !map_q[idx] && !(near_r && near_c);
  end

  // Next-state logic for FSM, board and free-running LFSR
  always_comb begin
    state_d = state_q;
    map_d   = map_q;
    count_d = count_q;
    srow_d  = srow_q;
    scol_d  = scol_q;
    lfsr_d  = {lfsr_q[14:0],
               lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    case (state_q)
      S_IDLE: begin
        if (mine_start) begin
          srow_d  = safe_row;
          scol_d  = safe_col;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        map_d   = '0;
        count_d = '0;
        state_d = mine_start ? S_GEN : S_IDLE;
      end
      S_GEN: begin
        if (!mine_start) begin
          state_d = S_IDLE;
        end else if (accept) begin
          map_d[idx] = 1'b1;
          count_d    = count_q + 6'd1;
          if (count_d == TARGET) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!mine_start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    done_d = (state_d == S_DONE);
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      lfsr_q  <= LFSR_SEED;
      map_q   <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      srow_q  <= '0;
      scol_q  <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      map_q   <= map_d;
      count_q <= count_d;
      done_q  <= done_d;
      srow_q  <= srow_d;
      scol_q  <= scol_d;
    end
  end

  assign busy       = (state_q == S_CLEAR) || (state_q == S_GEN);
  assign mine_done  = done_q;
  assign mine_map   = map_q;
  assign mine_count = count_q;

endmodule

// File: tb/tb_mine_placer.sv
// Bench for mine_placer: directed game table, random games, abort,
// async reset and a 55-mine corner game against a board-level model.
module tb_mine_placer;

  logic        clk = 1'b0;
  logic        rst;
  logic        st, st55;
  logic [2:0]  sr, sc, sr55, sc55;
  logic        done, busy, done55, busy55;
  logic [63:0] map, map55;
  logic [5:0]  cnt, cnt55;

  int errors = 0;
  int checks = 0;
  int unsigned edges;

  always #5 clk = ~clk;

  mine_placer dut (
    .clk(clk), .rst(rst), .mine_start(st),
    .safe_row(sr), .safe_col(sc),
    .mine_done(done), .busy(busy),
    .mine_map(map), .mine_count(cnt)
  );

  mine_placer #(.NUM_MINES(55)) dut55 (
    .clk(clk), .rst(rst), .mine_start(st55),
    .safe_row(sr55), .safe_col(sc55),
    .mine_done(done55), .busy(busy55),
    .mine_map(map55), .mine_count(cnt55)
  );

  // Clock edges seen since reset release; sets the LFSR phase
  always @(posedge clk or negedge rst)
    if (!rst) edges <= 0;
    else      edges <= edges + 1;

  function automatic logic [15:0] step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic int adiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic logic [63:0] zone(input int r, input int c);
    logic [63:0] z;
    z = '0;
    for (int i = 0; i < 64; i++)
      if (adiff(i / 8, r) <= 1 && adiff(i % 8, c) <= 1) z[i] = 1'b1;
    return z;
  endfunction

  // Expected board and GEN cycle count for a request seen after e edges
  function automatic void model(input int unsigned e, input int r,
                                input int c, input int n,
                                output logic [63:0] m, output int cyc);
    logic [15:0] l;
    logic [63:0] z;
    int placed, idx;
    l = 16'hACE1;
    for (int unsigned i = 0; i < e + 2; i++) l = step(l);
    z = zone(r, c);
    m = '0;
    cyc = 0;
    placed = 0;
    while (placed < n && cyc < 200000) begin
      idx = int'(l[5:0]);
      if (!m[idx] && !z[idx]) begin
        m[idx] = 1'b1;
        placed++;
      end
      cyc++;
      l = step(l);
    end
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic run_game(input int r, input int c, input int idle,
                          input int hold, input int exp_cnt,
                          output logic [63:0] got);
    logic [63:0] em;
    int ecyc, k;
    int unsigned e;
    st = 1'b0;
    repeat (idle) @(negedge clk);
    e = edges;
    model(e, r, c, 10, em, ecyc);
    sr = 3'(r);
    sc = 3'(c);
    st = 1'b1;
    @(negedge clk);
    check("busy_clear", 64'(busy), 64'd1);
    sr = ~sr;
    sc = ~sc;
    k = 1;
    while (!done && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check("latency", 64'(k), 64'(ecyc + 2));
    check("map", map, em);
    check("count", 64'(cnt), 64'(exp_cnt));
    check("popcount", 64'($countones(map)), 64'(exp_cnt));
    check("zone", map & zone(r, c), 64'd0);
    check("busy_done", 64'(busy), 64'd0);
    repeat (hold) begin
      @(negedge clk);
      check("done_hold", 64'(done), 64'd1);
    end
    st = 1'b0;
    @(negedge clk);
    check("done_drop", 64'(done), 64'd0);
    check("map_kept", map, em);
    got = map;
  endtask

  typedef struct {
    int r;
    int c;
    int idle;
    int hold;
    int exp_cnt;
  } vec_t;

  vec_t vecs[6];
  logic [63:0] g, m1, m2, em;
  int ecyc, k;

  initial begin
    vecs[0] = '{3, 3, 2, 5, 10};
    vecs[1] = '{0, 0, 1, 0, 10};
    vecs[2] = '{7, 7, 3, 1, 10};
    vecs[3] = '{0, 7, 4, 0, 10};
    vecs[4] = '{7, 0, 0, 2, 10};
    vecs[5] = '{4, 0, 5, 0, 10};

    rst = 1'b0;
    st = 1'b0; st55 = 1'b0;
    sr = '0; sc = '0; sr55 = '0; sc55 = '0;
    #1;
    check("rst_map", map, 64'd0);
    check("rst_out", {cnt, done, busy}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);

    for (int i = 0; i < 6; i++)
      run_game(vecs[i].r, vecs[i].c, vecs[i].idle,
               vecs[i].hold, vecs[i].exp_cnt, g);

    run_game(3, 3, 1, 0, 10, m1);
    run_game(3, 3, 6, 0, 10, m2);
    checks++;
    if (m1 === m2) begin
      errors++;
      $display("FAIL idle_entropy: got %h want different", m2);
    end

    for (int i = 0; i < 6; i++)
      run_game(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 7)), 0, 10, g);

    sr = 3'd5; sc = 3'd2; st = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_pre", 64'(busy), 64'd1);
    st = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    repeat (3) @(negedge clk);
    check("abort_idle", 64'(done | busy), 64'd0);
    run_game(2, 5, 0, 0, 10, g);

    sr = 3'd1; sc = 3'd6; st = 1'b1;
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b0;
    st = 1'b0;
    #1;
    check("arst_map", map, 64'd0);
    check("arst_out", {cnt, done, busy}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle", 64'(busy), 64'd0);
    run_game(1, 6, 0, 0, 10, g);

    model(edges, 0, 0, 55, em, ecyc);
    sr55 = 3'd0; sc55 = 3'd0; st55 = 1'b1;
    k = 0;
    while (!done55 && k < 20000) begin
      @(negedge clk);
      k++;
    end
    check("m55_latency", 64'(k), 64'(ecyc + 2));
    check("m55_map", map55, em);
    check("m55_count", 64'(cnt55), 64'd55);
    check("m55_pop", 64'($countones(map55)), 64'd55);
    check("m55_corner", {map55[9], map55[8], map55[1], map55[0]}, 64'd0);
    check("m55_wrap", {map55[7], map55[56], map55[63]}, 64'h7);
    st55 = 1'b0;
    @(negedge clk);
    check("m55_drop", 64'(done55), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
